// File: rtl/stg_mo_pkg.sv
// Shared sizes, opcodes, FSM state encoding and op-class decode for the
// memory-operation stage.
package stg_mo_pkg;

    localparam int SIZE_DATA     = 24;
    localparam int SIZE_ADDR     = 48;
    localparam int SIZE_OPC      = 8;
    localparam int SIZE_STALLCNT = 16;
    localparam int SIZE_TGT_GP   = 4;
    localparam int SIZE_TGT_SR   = 2;
    localparam int SIZE_TGT_AR   = 2;

    typedef logic [SIZE_OPC-1:0] opc_t;

    localparam opc_t OPC_LDUR   = 8'h20;
    localparam opc_t OPC_LDSO   = 8'h21;
    localparam opc_t OPC_STUR   = 8'h30;
    localparam opc_t OPC_STSO   = 8'h31;
    localparam opc_t OPC_STUI   = 8'h32;
    localparam opc_t OPC_STSI   = 8'h33;
    localparam opc_t OPC_SRLDSO = 8'h40;
    localparam opc_t OPC_LDASO  = 8'h41;
    localparam opc_t OPC_SRSTSO = 8'h50;
    localparam opc_t OPC_STASO  = 8'h51;

    typedef enum logic {
        MO_RUN  = 1'b0,
        MO_WAIT = 1'b1
    } mo_state_t;

    function automatic logic is_ld24(input opc_t opc);
        return (opc == OPC_LDUR) || (opc == OPC_LDSO);
    endfunction

    function automatic logic is_st24(input opc_t opc);
        return (opc == OPC_STUR) || (opc == OPC_STSO) ||
               (opc == OPC_STUI) || (opc == OPC_STSI);
    endfunction

    function automatic logic is_ld48(input opc_t opc);
        return (opc == OPC_SRLDSO) || (opc == OPC_LDASO);
    endfunction

    function automatic logic is_st48(input opc_t opc);
        return (opc == OPC_SRSTSO) || (opc == OPC_STASO);
    endfunction

endpackage

// File: rtl/mo_port_mux.sv
// Combinational port steering: store data onto the memory ports and
// load data back into the 24-bit or 48-bit result fields.
module mo_port_mux
    import stg_mo_pkg::*;
(
    input  logic                 p,
    input  logic [SIZE_OPC-1:0]  opc,
    input  logic                 go,
    input  logic                 rst,
    input  logic [SIZE_DATA-1:0] result,
    input  logic [SIZE_ADDR-1:0] sr_result,
    input  logic [SIZE_ADDR-1:0] ar_result,
    input  logic [SIZE_DATA-1:0] rdata0,
    input  logic [SIZE_DATA-1:0] rdata1,
    output logic                 we0,
    output logic                 we1,
    output logic [SIZE_DATA-1:0] wdata0,
    output logic [SIZE_DATA-1:0] wdata1,
    output logic [SIZE_DATA-1:0] ld_result,
    output logic [SIZE_ADDR-1:0] ld_sr_result,
    output logic [SIZE_ADDR-1:0] ld_ar_result
);

    // 48-bit stores put the low half on port 0 and the high half on port 1.
    always_comb begin
        we0    = 1'b0;
        we1    = 1'b0;
        wdata0 = '0;
        wdata1 = '0;
        if (go) begin
            if (is_st24(opc)) begin
                if (p) begin
                    we1    = 1'b1;
                    wdata1 = result;
                end else begin
                    we0    = 1'b1;
                    wdata0 = result;
                end
            end else if (is_st48(opc)) begin
                we0 = 1'b1;
                we1 = 1'b1;
                if (opc == OPC_SRSTSO) begin
                    wdata0 = sr_result[SIZE_DATA-1:0];
                    wdata1 = sr_result[SIZE_ADDR-1:SIZE_DATA];
                end else begin
                    wdata0 = ar_result[SIZE_DATA-1:0];
                    wdata1 = ar_result[SIZE_ADDR-1:SIZE_DATA];
                end
            end
        end
        if (rst) begin
            we0 = 1'b0;
            we1 = 1'b0;
        end
    end

    always_comb begin
        ld_result    = result;
        ld_sr_result = sr_result;
        ld_ar_result = ar_result;
        if (is_ld24(opc)) begin
            ld_result = p ? rdata1 : rdata0;
        end else if (opc == OPC_SRLDSO) begin
            ld_sr_result = {rdata1, rdata0};
        end else if (opc == OPC_LDASO) begin
            ld_ar_result = {rdata1, rdata0};
        end
    end

endmodule

// File: rtl/stg_mo.sv
// Memory-operation stage: drives the dual-port data memory, stalls while a
// needed port is busy, and registers the result toward writeback.
module stg_mo
    import stg_mo_pkg::*;
(
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic [SIZE_ADDR-1:0]     iw_pc,
    input  logic [SIZE_DATA-1:0]     iw_instr,
    input  logic [SIZE_OPC-1:0]      iw_opc,
    input  logic [SIZE_TGT_GP-1:0]   iw_tgt_gp,
    input  logic                     iw_tgt_gp_we,
    input  logic [SIZE_TGT_SR-1:0]   iw_tgt_sr,
    input  logic                     iw_tgt_sr_we,
    input  logic [SIZE_TGT_AR-1:0]   iw_tgt_ar,
    input  logic                     iw_tgt_ar_we,
    input  logic                     iw_mem_mp,
    input  logic [SIZE_DATA-1:0]     iw_result,
    input  logic [SIZE_ADDR-1:0]     iw_sr_result,
    input  logic [SIZE_ADDR-1:0]     iw_ar_result,
    input  logic [SIZE_DATA-1:0]     iw_mem_rdata0,
    input  logic [SIZE_DATA-1:0]     iw_mem_rdata1,
    input  logic [1:0]               iw_mem_busy,
    output logic                     ow_mem_we0,
    output logic                     ow_mem_we1,
    output logic [SIZE_DATA-1:0]     ow_mem_wdata0,
    output logic [SIZE_DATA-1:0]     ow_mem_wdata1,
    output logic                     ow_stall,
    output logic [SIZE_ADDR-1:0]     ow_pc,
    output logic [SIZE_DATA-1:0]     ow_instr,
    output logic [SIZE_OPC-1:0]      ow_opc,
    output logic [SIZE_TGT_GP-1:0]   ow_tgt_gp,
    output logic                     ow_tgt_gp_we,
    output logic [SIZE_TGT_SR-1:0]   ow_tgt_sr,
    output logic                     ow_tgt_sr_we,
    output logic [SIZE_TGT_AR-1:0]   ow_tgt_ar,
    output logic                     ow_tgt_ar_we,
    output logic [SIZE_DATA-1:0]     ow_result,
    output logic [SIZE_ADDR-1:0]     ow_sr_result,
    output logic [SIZE_ADDR-1:0]     ow_ar_result,
    output logic [SIZE_STALLCNT-1:0] ow_stall_cnt
);

    logic                 op24;
    logic                 op48;
    logic                 mem_op;
    logic [1:0]           need;
    logic                 go;
    logic [SIZE_DATA-1:0] ld_result;
    logic [SIZE_ADDR-1:0] ld_sr_result;
    logic [SIZE_ADDR-1:0] ld_ar_result;
    mo_state_t            state;
    mo_state_t            state_next;

    assign op24     = is_ld24(iw_opc) | is_st24(iw_opc);
    assign op48     = is_ld48(iw_opc) | is_st48(iw_opc);
    assign mem_op   = op24 | op48;
    assign need     = op48 ? 2'b11 : (op24 ? (iw_mem_mp ? 2'b10 : 2'b01) : 2'b00);
    assign go       = (need & iw_mem_busy) == 2'b00;
    assign ow_stall = mem_op & ~go & ~iw_rst;

    mo_port_mux u_port_mux (
        .p            (iw_mem_mp),
        .opc          (iw_opc),
        .go           (go),
        .rst          (iw_rst),
        .result       (iw_result),
        .sr_result    (iw_sr_result),
        .ar_result    (iw_ar_result),
        .rdata0       (iw_mem_rdata0),
        .rdata1       (iw_mem_rdata1),
        .we0          (ow_mem_we0),
        .we1          (ow_mem_we1),
        .wdata0       (ow_mem_wdata0),
        .wdata1       (ow_mem_wdata1),
        .ld_result    (ld_result),
        .ld_sr_result (ld_sr_result),
        .ld_ar_result (ld_ar_result)
    );

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state <= MO_RUN;
        end else begin
            state <= state_next;
        end
    end

    // The access completes in the cycle WAIT sees go, so no extra cycle is spent.
    always_comb begin
        state_next = state;
        case (state)
            MO_RUN:  if (mem_op && !go) state_next = MO_WAIT;
            MO_WAIT: if (go) state_next = MO_RUN;
            default: state_next = MO_RUN;
        endcase
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            ow_pc        <= '0;
            ow_instr     <= '0;
            ow_opc       <= '0;
            ow_tgt_gp    <= '0;
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr    <= '0;
            ow_tgt_sr_we <= 1'b0;
            ow_tgt_ar    <= '0;
            ow_tgt_ar_we <= 1'b0;
            ow_result    <= '0;
            ow_sr_result <= '0;
            ow_ar_result <= '0;
        end else if (ow_stall) begin
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr_we <= 1'b0;
            ow_tgt_ar_we <= 1'b0;
        end else begin
            ow_pc        <= iw_pc;
            ow_instr     <= iw_instr;
            ow_opc       <= iw_opc;
            ow_tgt_gp    <= iw_tgt_gp;
            ow_tgt_gp_we <= iw_tgt_gp_we;
            ow_tgt_sr    <= iw_tgt_sr;
            ow_tgt_sr_we <= iw_tgt_sr_we;
            ow_tgt_ar    <= iw_tgt_ar;
            ow_tgt_ar_we <= iw_tgt_ar_we;
            ow_result    <= ld_result;
            ow_sr_result <= ld_sr_result;
            ow_ar_result <= ld_ar_result;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            ow_stall_cnt <= '0;
        end else if (ow_stall && (ow_stall_cnt != '1)) begin
            ow_stall_cnt <= ow_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stg_mo.sv
// Self-checking bench for stg_mo: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the stage.
module tb_stg_mo;
    import stg_mo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] pc;
    logic [23:0] instr;
    logic [7:0]  opc;
    logic [3:0]  tgt_gp;
    logic        tgt_gp_we;
    logic [1:0]  tgt_sr;
    logic        tgt_sr_we;
    logic [1:0]  tgt_ar;
    logic        tgt_ar_we;
    logic        mem_mp;
    logic [23:0] result;
    logic [47:0] sr_result;
    logic [47:0] ar_result;
    logic [23:0] rdata0;
    logic [23:0] rdata1;
    logic [1:0]  mem_busy;

    logic        o_we0, o_we1, o_stall;
    logic [23:0] o_wdata0, o_wdata1;
    logic [47:0] o_pc;
    logic [23:0] o_instr;
    logic [7:0]  o_opc;
    logic [3:0]  o_tgt_gp;
    logic        o_tgt_gp_we;
    logic [1:0]  o_tgt_sr;
    logic        o_tgt_sr_we;
    logic [1:0]  o_tgt_ar;
    logic        o_tgt_ar_we;
    logic [23:0] o_result;
    logic [47:0] o_sr_result;
    logic [47:0] o_ar_result;
    logic [15:0] o_stall_cnt;

    int total = 0;
    int bad   = 0;

    // Model of the writeback-facing register and the stall counter.
    logic [47:0] m_pc;
    logic [23:0] m_instr;
    logic [7:0]  m_opc;
    logic [3:0]  m_tgt_gp;
    logic        m_gp_we;
    logic [1:0]  m_tgt_sr;
    logic        m_sr_we;
    logic [1:0]  m_tgt_ar;
    logic        m_ar_we;
    logic [23:0] m_result;
    logic [47:0] m_sr;
    logic [47:0] m_ar;
    int          m_cnt;
    logic        last_stall = 1'b0;

    logic [7:0] op_tbl [12] = '{OPC_LDUR, OPC_LDSO, OPC_STUR, OPC_STSO, OPC_STUI, OPC_STSI,
                               OPC_SRLDSO, OPC_LDASO, OPC_SRSTSO, OPC_STASO, 8'h01, 8'h02};

    always #5 clk = ~clk;

    stg_mo dut (
        .iw_clk        (clk),
        .iw_rst        (rst),
        .iw_pc         (pc),
        .iw_instr      (instr),
        .iw_opc        (opc),
        .iw_tgt_gp     (tgt_gp),
        .iw_tgt_gp_we  (tgt_gp_we),
        .iw_tgt_sr     (tgt_sr),
        .iw_tgt_sr_we  (tgt_sr_we),
        .iw_tgt_ar     (tgt_ar),
        .iw_tgt_ar_we  (tgt_ar_we),
        .iw_mem_mp     (mem_mp),
        .iw_result     (result),
        .iw_sr_result  (sr_result),
        .iw_ar_result  (ar_result),
        .iw_mem_rdata0 (rdata0),
        .iw_mem_rdata1 (rdata1),
        .iw_mem_busy   (mem_busy),
        .ow_mem_we0    (o_we0),
        .ow_mem_we1    (o_we1),
        .ow_mem_wdata0 (o_wdata0),
        .ow_mem_wdata1 (o_wdata1),
        .ow_stall      (o_stall),
        .ow_pc         (o_pc),
        .ow_instr      (o_instr),
        .ow_opc        (o_opc),
        .ow_tgt_gp     (o_tgt_gp),
        .ow_tgt_gp_we  (o_tgt_gp_we),
        .ow_tgt_sr     (o_tgt_sr),
        .ow_tgt_sr_we  (o_tgt_sr_we),
        .ow_tgt_ar     (o_tgt_ar),
        .ow_tgt_ar_we  (o_tgt_ar_we),
        .ow_result     (o_result),
        .ow_sr_result  (o_sr_result),
        .ow_ar_result  (o_ar_result),
        .ow_stall_cnt  (o_stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // 0 = non-memory, 1 = 24-bit load, 2 = 24-bit store, 3 = 48-bit load, 4 = 48-bit store
    function automatic int op_class(input logic [7:0] op);
        case (op)
            OPC_LDUR, OPC_LDSO:                       return 1;
            OPC_STUR, OPC_STSO, OPC_STUI, OPC_STSI:   return 2;
            OPC_SRLDSO, OPC_LDASO:                    return 3;
            OPC_SRSTSO, OPC_STASO:                    return 4;
            default:                                  return 0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [7:0] op, input logic mp, input logic [1:0] busy, input logic r);
        @(negedge clk);
        opc       = op;
        mem_mp    = mp;
        mem_busy  = busy;
        rst       = r;
        pc        = 48'({$urandom(), $urandom()});
        instr     = 24'($urandom());
        tgt_gp    = 4'($urandom());
        tgt_gp_we = 1'($urandom());
        tgt_sr    = 2'($urandom());
        tgt_sr_we = 1'($urandom());
        tgt_ar    = 2'($urandom());
        tgt_ar_we = 1'($urandom());
        result    = 24'($urandom());
        sr_result = 48'({$urandom(), $urandom()});
        ar_result = 48'({$urandom(), $urandom()});
        rdata0    = 24'($urandom());
        rdata1    = 24'($urandom());
    endtask

    // One clock cycle: check the combinational memory side against the model,
    // advance the model across the edge, then check the registered side.
    task automatic step();
        int          cls;
        logic        need0, need1, go_m, stall_m, e_we0, e_we1;
        logic [23:0] e_wd0, e_wd1;
        logic [47:0] wide;
        #1;
        cls     = op_class(opc);
        need0   = (cls >= 3) || (cls != 0 && !mem_mp);
        need1   = (cls >= 3) || (cls != 0 && mem_mp);
        go_m    = !(need0 && mem_busy[0]) && !(need1 && mem_busy[1]);
        stall_m = (cls != 0) && !go_m && !rst;
        e_we0 = 1'b0; e_we1 = 1'b0; e_wd0 = '0; e_wd1 = '0;
        if (go_m && cls == 2) begin
            if (mem_mp) begin e_we1 = !rst; e_wd1 = result; end
            else        begin e_we0 = !rst; e_wd0 = result; end
        end
        if (go_m && cls == 4) begin
            wide  = (opc == OPC_SRSTSO) ? sr_result : ar_result;
            e_we0 = !rst;
            e_we1 = !rst;
            e_wd0 = wide[23:0];
            e_wd1 = wide[47:24];
        end
        checkOutput("stall",  64'(o_stall),  64'(stall_m));
        checkOutput("we0",    64'(o_we0),    64'(e_we0));
        checkOutput("we1",    64'(o_we1),    64'(e_we1));
        checkOutput("wdata0", 64'(o_wdata0), 64'(e_wd0));
        checkOutput("wdata1", 64'(o_wdata1), 64'(e_wd1));
        last_stall = stall_m;
        @(posedge clk);
        if (rst) begin
            m_pc = '0; m_instr = '0; m_opc = '0; m_tgt_gp = '0; m_gp_we = 0;
            m_tgt_sr = '0; m_sr_we = 0; m_tgt_ar = '0; m_ar_we = 0;
            m_result = '0; m_sr = '0; m_ar = '0; m_cnt = 0;
        end else if (stall_m) begin
            if (m_cnt < 65535) m_cnt++;
            m_gp_we = 0; m_sr_we = 0; m_ar_we = 0;
        end else begin
            m_pc = pc; m_instr = instr; m_opc = opc;
            m_tgt_gp = tgt_gp; m_gp_we = tgt_gp_we;
            m_tgt_sr = tgt_sr; m_sr_we = tgt_sr_we;
            m_tgt_ar = tgt_ar; m_ar_we = tgt_ar_we;
            m_result = result; m_sr = sr_result; m_ar = ar_result;
            if (cls == 1)               m_result = mem_mp ? rdata1 : rdata0;
            if (opc == OPC_SRLDSO)      m_sr = {rdata1, rdata0};
            else if (opc == OPC_LDASO)  m_ar = {rdata1, rdata0};
        end
        #1;
        checkOutput("pc",        64'(o_pc),        64'(m_pc));
        checkOutput("instr",     64'(o_instr),     64'(m_instr));
        checkOutput("opc",       64'(o_opc),       64'(m_opc));
        checkOutput("tgt_gp",    64'(o_tgt_gp),    64'(m_tgt_gp));
        checkOutput("tgt_gp_we", 64'(o_tgt_gp_we), 64'(m_gp_we));
        checkOutput("tgt_sr",    64'(o_tgt_sr),    64'(m_tgt_sr));
        checkOutput("tgt_sr_we", 64'(o_tgt_sr_we), 64'(m_sr_we));
        checkOutput("tgt_ar",    64'(o_tgt_ar),    64'(m_tgt_ar));
        checkOutput("tgt_ar_we", 64'(o_tgt_ar_we), 64'(m_ar_we));
        checkOutput("result",    64'(o_result),    64'(m_result));
        checkOutput("sr_result", 64'(o_sr_result), 64'(m_sr));
        checkOutput("ar_result", 64'(o_ar_result), 64'(m_ar));
        checkOutput("stall_cnt", 64'(o_stall_cnt), 64'(m_cnt));
    endtask

    task automatic setBusy(input logic [1:0] busy);
        @(negedge clk);
        mem_busy = busy;
    endtask

    initial begin
        m_cnt = 0;
        applyStimulus(8'h01, 1'b0, 2'b00, 1'b1);
        step();
        checkOutput("reset_cnt", 64'(o_stall_cnt), 64'h0);
        checkOutput("reset_opc", 64'(o_opc), 64'h0);

        // 24-bit store on port 1
        applyStimulus(OPC_STUR, 1'b1, 2'b00, 1'b0);
        result = 24'hABCDEF;
        step();
        checkOutput("stur_we1",    64'(o_we1), 64'h1);
        checkOutput("stur_wdata1", 64'(o_wdata1), 64'hABCDEF);
        checkOutput("stur_we0",    64'(o_we0), 64'h0);
        checkOutput("stur_opc",    64'(o_opc), 64'(OPC_STUR));

        // 24-bit load from port 0
        applyStimulus(OPC_LDSO, 1'b0, 2'b00, 1'b0);
        rdata0 = 24'h123456;
        tgt_gp_we = 1'b1;
        step();
        checkOutput("ldso_result", 64'(o_result), 64'h123456);
        checkOutput("ldso_gp_we",  64'(o_tgt_gp_we), 64'h1);

        // 48-bit SR store split across both ports
        applyStimulus(OPC_SRSTSO, 1'b0, 2'b00, 1'b0);
        sr_result = 48'h00AA_BB11_22CC;
        step();
        checkOutput("srst_wdata0", 64'(o_wdata0), 64'h1122CC);
        checkOutput("srst_wdata1", 64'(o_wdata1), 64'h00AABB);

        // 48-bit AR load waiting three cycles on port 1
        applyStimulus(8'h01, 1'b0, 2'b00, 1'b1);
        step();
        applyStimulus(OPC_LDASO, 1'b0, 2'b10, 1'b0);
        rdata1 = 24'h000001;
        rdata0 = 24'hFFFFFF;
        tgt_ar_we = 1'b1;
        step();
        step();
        step();
        setBusy(2'b00);
        step();
        checkOutput("ldaso_ar",  64'(o_ar_result), 64'h000001FFFFFF);
        checkOutput("ldaso_cnt", 64'(o_stall_cnt), 64'd3);

        // Stalled store dropped by reset
        applyStimulus(OPC_STSO, 1'b0, 2'b01, 1'b0);
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        checkOutput("rst_drop_cnt", 64'(o_stall_cnt), 64'h0);
        checkOutput("rst_drop_we0", 64'(o_we0), 64'h0);
        applyStimulus(8'h02, 1'b0, 2'b01, 1'b0);
        step();

        // Counter saturation
        applyStimulus(8'h01, 1'b0, 2'b00, 1'b1);
        step();
        applyStimulus(OPC_STUR, 1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 65534; i++) step();
        checkOutput("cnt_fffe", 64'(o_stall_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) step();
        checkOutput("cnt_sat", 64'(o_stall_cnt), 64'hFFFF);
        applyStimulus(8'h01, 1'b0, 2'b11, 1'b0);
        step();
        checkOutput("nonmem_busy_stall", 64'(o_stall), 64'h0);
        checkOutput("cnt_hold", 64'(o_stall_cnt), 64'hFFFF);

        // Randomized traffic, inputs held by "upstream" while stalled
        applyStimulus(8'h01, 1'b0, 2'b00, 1'b1);
        step();
        for (int i = 0; i < 400; i++) begin
            if (last_stall) begin
                @(negedge clk);
                mem_busy = ($urandom_range(0, 1) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                rdata0   = 24'($urandom());
                rdata1   = 24'($urandom());
                rst      = ($urandom_range(0, 30) == 0);
            end else begin
                applyStimulus(($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                          : op_tbl[$urandom_range(0, 11)],
                              1'($urandom_range(0, 1)),
                              ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                              ($urandom_range(0, 40) == 0));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
